// File: rtl/ram32_lsu_port.sv
// rtl/ram32_lsu_port.sv - byte/half/word load-store front-end for a byte-enabled 32-bit synchronous RAM
module ram32_lsu_port #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_error,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [31:0]           ram_data,
    output logic [3:0]            ram_wren,
    input  logic [31:0]           ram_q
);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    logic                  s1_valid;
    logic [ADDR_WIDTH-1:0] s1_addr;
    logic [1:0]            s1_off;
    logic [1:0]            s1_size;
    logic                  s1_unsigned;
    logic                  s1_write;
    logic                  s1_error;

    logic        s1_adv;
    logic        fire;
    logic        req_error;
    logic [3:0]  req_mask;
    logic [31:0] lane;
    logic [31:0] aligned;

    // S1 may hand off when OUT is empty or being drained this cycle.
    assign s1_adv    = s1_valid && (!rsp_valid || rsp_ready);
    assign req_ready = reset_n && (!s1_valid || s1_adv);
    assign fire      = req_valid && req_ready;

    always_comb begin
        req_error = 1'b0;
        case (req_size)
            SIZE_BYTE: req_error = 1'b0;
            SIZE_HALF: req_error = req_addr[0];
            SIZE_WORD: req_error = |req_addr[1:0];
            default:   req_error = 1'b1;
        endcase
    end

    always_comb begin
        req_mask = 4'b0000;
        ram_data = req_wdata;
        case (req_size)
            SIZE_BYTE: begin
                req_mask = 4'b0001 << req_addr[1:0];
                ram_data = {4{req_wdata[7:0]}};
            end
            SIZE_HALF: begin
                req_mask = req_addr[1] ? 4'b1100 : 4'b0011;
                ram_data = {2{req_wdata[15:0]}};
            end
            SIZE_WORD: begin
                req_mask = 4'b1111;
                ram_data = req_wdata;
            end
            default: begin
                req_mask = 4'b0000;
                ram_data = req_wdata;
            end
        endcase
    end

    assign ram_wren = (fire && req_write && !req_error) ? req_mask : 4'b0000;

    // While S1 is held, re-present its address so ram_q keeps the word S1 needs.
    assign ram_address = (s1_valid && !s1_adv) ? s1_addr : req_addr;

    assign lane = ram_q >> {s1_off, 3'b000};

    always_comb begin
        aligned = lane;
        case (s1_size)
            SIZE_BYTE: aligned = s1_unsigned ? {24'h000000, lane[7:0]}
                                             : {{24{lane[7]}}, lane[7:0]};
            SIZE_HALF: aligned = s1_unsigned ? {16'h0000, lane[15:0]}
                                             : {{16{lane[15]}}, lane[15:0]};
            default:   aligned = lane;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid    <= 1'b0;
            s1_addr     <= '0;
            s1_off      <= 2'b00;
            s1_size     <= 2'b00;
            s1_unsigned <= 1'b0;
            s1_write    <= 1'b0;
            s1_error    <= 1'b0;
        end else if (fire) begin
            s1_valid    <= 1'b1;
            s1_addr     <= req_addr;
            s1_off      <= req_addr[1:0];
            s1_size     <= req_size;
            s1_unsigned <= req_unsigned;
            s1_write    <= req_write;
            s1_error    <= req_error;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_error <= 1'b0;
        end else if (s1_adv) begin
            rsp_valid <= 1'b1;
            rsp_error <= s1_error;
            rsp_rdata <= (s1_write || s1_error) ? 32'h0 : aligned;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ram32_lsu_port.sv
// tb/tb_ram32_lsu_port.sv - scoreboard bench for ram32_lsu_port with a behavioural byte-enabled RAM
module tb_ram32_lsu_port;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [15:0] ram_address;
    logic [31:0] ram_data;
    logic [3:0]  ram_wren;
    logic [31:0] ram_q;

    int n_cmp = 0;
    int n_bad = 0;
    logic [32:0] sb[$];
    logic [31:0] mem [0:255];

    always #5 clock = ~clock;

    ram32_lsu_port #(.ADDR_WIDTH(16)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_error(rsp_error), .ram_address(ram_address),
        .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
    );

    always @(posedge clock) begin
        for (int b = 0; b < 4; b++)
            if (ram_wren[b]) mem[ram_address[9:2]][8*b +: 8] <= ram_data[8*b +: 8];
        ram_q <= mem[ram_address[9:2]];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (reset_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 64'(rsp_rdata), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                logic [32:0] e;
                e = sb.pop_front();
                check("rsp_error", 64'(rsp_error), 64'(e[32]));
                check("rsp_rdata", 64'(rsp_rdata), 64'(e[31:0]));
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic w, input logic [1:0] sz,
                        input logic u, input logic [31:0] wd, input logic [3:0] exp_wren,
                        input logic [31:0] exp_data, input logic exp_err, input logic [31:0] exp_rd);
        int waited;
        bit fired;
        req_valid = 1'b1; req_addr = a; req_write = w; req_size = sz;
        req_unsigned = u; req_wdata = wd;
        waited = 0;
        fired = 1'b0;
        while (!fired && waited < 50) begin
            @(negedge clock);
            if (req_ready) fired = 1'b1;
            else waited++;
        end
        if (!fired) begin
            check("req_timeout", 64'd0, 64'd1);
        end else begin
            check("ram_wren", 64'(ram_wren), 64'(exp_wren));
            if (exp_wren != 4'b0000) check("ram_data", 64'(ram_data), 64'(exp_data));
            sb.push_back({exp_err, exp_rd});
        end
        @(posedge clock);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (sb.size() != 0 && waited < 100) begin
            @(posedge clock);
            waited++;
        end
        check("drain", 64'(sb.size()), 64'd0);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        ram_q = 32'h0;
        reset_n = 1'b0; rsp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 16'h0; req_write = 1'b1; req_size = 2'b10;
        req_unsigned = 1'b0; req_wdata = 32'h5555_5555;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_ram_wren", 64'(ram_wren), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_rsp_error", 64'(rsp_error), 64'd0);
        req_valid = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Store word, then check two-edge response latency.
        send(16'h0010, 1, 2'b10, 0, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 0, 32'h0);
        check("lat_not_yet", 64'(rsp_valid), 64'd0);
        @(posedge clock); #1;
        check("lat_valid", 64'(rsp_valid), 64'd1);
        send(16'h0020, 1, 2'b10, 0, 32'h8001_7F02, 4'b1111, 32'h8001_7F02, 0, 32'h0);

        send(16'h0013, 0, 2'b00, 1, 32'h0, 4'b0000, 32'h0, 0, 32'h0000_00DE);
        send(16'h0013, 0, 2'b00, 0, 32'h0, 4'b0000, 32'h0, 0, 32'hFFFF_FFDE);

        send(16'h0012, 1, 2'b01, 0, 32'h0000_1234, 4'b1100, 32'h1234_1234, 0, 32'h0);
        send(16'h0010, 0, 2'b10, 0, 32'h0, 4'b0000, 32'h0, 0, 32'h1234_BEEF);

        send(16'h0011, 0, 2'b10, 0, 32'h0, 4'b0000, 32'h0, 1, 32'h0);
        send(16'h0013, 1, 2'b01, 0, 32'h0000_FFFF, 4'b0000, 32'h0, 1, 32'h0);
        send(16'h0010, 1, 2'b11, 0, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1, 32'h0);
        send(16'h0010, 0, 2'b10, 0, 32'h0, 4'b0000, 32'h0, 0, 32'h1234_BEEF);

        send(16'h0011, 1, 2'b00, 0, 32'h0000_00A5, 4'b0010, 32'hA5A5_A5A5, 0, 32'h0);
        send(16'h0010, 0, 2'b01, 0, 32'h0, 4'b0000, 32'h0, 0, 32'hFFFF_A5EF);
        send(16'h0012, 0, 2'b01, 1, 32'h0, 4'b0000, 32'h0, 0, 32'h0000_1234);
        send(16'h0010, 0, 2'b00, 0, 32'h0, 4'b0000, 32'h0, 0, 32'hFFFF_FFEF);
        drain();

        // Backpressure: third request must wait, RAM address replays the held one.
        rsp_ready = 1'b0;
        send(16'h0010, 0, 2'b10, 0, 32'h0, 4'b0000, 32'h0, 0, 32'h1234_A5EF);
        send(16'h0012, 0, 2'b00, 1, 32'h0, 4'b0000, 32'h0, 0, 32'h0000_0034);
        req_valid = 1'b1; req_addr = 16'h0022; req_write = 1'b0; req_size = 2'b01;
        req_unsigned = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            check("bp_req_ready", 64'(req_ready), 64'd0);
            check("bp_ram_address", 64'(ram_address), 64'h12);
            check("bp_ram_wren", 64'(ram_wren), 64'd0);
        end
        @(posedge clock); #1;
        rsp_ready = 1'b1;
        send(16'h0022, 0, 2'b01, 0, 32'h0, 4'b0000, 32'h0, 0, 32'hFFFF_8001);
        drain();

        // Reset with S1 and OUT both occupied.
        rsp_ready = 1'b0;
        send(16'h0010, 0, 2'b10, 0, 32'h0, 4'b0000, 32'h0, 0, 32'h1234_A5EF);
        send(16'h0020, 0, 2'b10, 0, 32'h0, 4'b0000, 32'h0, 0, 32'h8001_7F02);
        reset_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_req_ready", 64'(req_ready), 64'd0);
        sb.delete();
        @(posedge clock); #1;
        reset_n = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        send(16'h0020, 0, 2'b10, 0, 32'h0, 4'b0000, 32'h0, 0, 32'h8001_7F02);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
